serial_out_arbiter: RTL

//  Shares the design's single-bit serial output line OUT between NREQ requesters.

---
 rtl/serial_out_arbiter_pkg.sv | 19 +
 rtl/serial_out_arbiter_if.sv | 33 +++
 rtl/serial_out_arbiter_rr_arbiter.sv | 31 +++
 rtl/serial_out_arbiter.sv | 132 +++++++++++++
 4 files changed

// File: rtl/serial_out_arbiter_pkg.sv
// rtl/serial_out_arbiter_pkg.sv - FSM encodings, line levels and sizing helper for the serial output arbiter
package serial_out_arbiter_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;

  localparam logic LVL_IDLE  = 1'b1;
  localparam logic LVL_START = 1'b0;
  localparam logic LVL_STOP  = 1'b1;

  // Index width that stays at least one bit wide for a single requester.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_out_arbiter_if.sv
// rtl/serial_out_arbiter_if.sv - requester-side bundle and serial line of the output arbiter
interface serial_out_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 8,
  parameter int SW   = serial_out_arbiter_pkg::idx_w(NREQ)
);

  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] data_in;
  logic [NREQ-1:0]    ack;
  logic [SW-1:0]      S;
  logic               busy;
  logic               OUT;

  modport master (
    output req,
    output data_in,
    input  ack,
    input  S,
    input  busy,
    input  OUT
  );

  modport slave (
    input  req,
    input  data_in,
    output ack,
    output S,
    output busy,
    output OUT
  );

endinterface

// File: rtl/serial_out_arbiter_rr_arbiter.sv
// rtl/serial_out_arbiter_rr_arbiter.sv - combinational round-robin pick of the first request at or above ptr
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int SW   = serial_out_arbiter_pkg::idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [SW-1:0]   ptr,
  output logic [SW-1:0]   grant,
  output logic            valid
);

  int off;
  int best;

  // Each requester's distance above ptr (mod NREQ); the closest one wins.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    off   = 0;
    best  = NREQ;
    for (int j = 0; j < NREQ; j++) begin
      off = (j - int'(ptr) + NREQ) % NREQ;
      if (req[j] && (off < best)) begin
        best  = off;
        grant = SW'(j);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/serial_out_arbiter.sv
// rtl/serial_out_arbiter.sv - round-robin sharing of one serial line; frames are start 0, DW bits LSB first, stop 1
module serial_out_arbiter
  import serial_out_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW   = 8,
  parameter int GAP  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_out_arbiter_if.slave  bus
);

  localparam int SW = idx_w(NREQ);
  localparam int CW = $clog2(DW + 1);
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

  logic [2:0]      state;
  logic [DW-1:0]   shreg;
  logic [CW-1:0]   bitcnt;
  logic [GW-1:0]   gapcnt;
  logic [SW-1:0]   ptr;

  logic [SW-1:0]   gidx;
  logic            gvalid;
  logic [DW-1:0]   gword;
  logic            frame_end;
  logic            grant_now;

  logic [NREQ-1:0] ack_r;
  logic [SW-1:0]   s_r;
  logic            busy_r;
  logic            out_r;

  assign bus.ack  = ack_r;
  assign bus.S    = s_r;
  assign bus.busy = busy_r;
  assign bus.OUT  = out_r;

  rr_arbiter #(
    .NREQ (NREQ),
    .SW   (SW)
  ) u_arb (
    .req   (bus.req),
    .ptr   (ptr),
    .grant (gidx),
    .valid (gvalid)
  );

  always_comb begin
    gword = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gidx == SW'(i)) gword = bus.data_in[i*DW +: DW];
    end
  end

  // The edge that would return to IDLE also arbitrates, keeping held requests at the frame period.
  assign frame_end = ((state == ST_GAP) && (gapcnt == GW'(GAP))) ||
                     ((state == ST_STOP) && (GAP == 0));
  assign grant_now = ((state == ST_IDLE) || frame_end) && gvalid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      shreg  <= '0;
      bitcnt <= '0;
      gapcnt <= '0;
      ptr    <= '0;
      ack_r  <= '0;
      s_r    <= '0;
      busy_r <= 1'b0;
      out_r  <= LVL_IDLE;
    end else if (grant_now) begin
      state  <= ST_START;
      shreg  <= gword;
      bitcnt <= '0;
      gapcnt <= '0;
      ptr    <= (gidx == SW'(NREQ - 1)) ? '0 : gidx + 1'b1;
      ack_r  <= NREQ'(1) << gidx;
      s_r    <= gidx;
      busy_r <= 1'b1;
      out_r  <= LVL_START;
    end else begin
      ack_r <= '0;
      case (state)
        ST_START: begin
          state  <= ST_DATA;
          out_r  <= shreg[0];
          shreg  <= shreg >> 1;
          bitcnt <= CW'(1);
        end
        ST_DATA: begin
          if (bitcnt == CW'(DW)) begin
            state  <= ST_STOP;
            out_r  <= LVL_STOP;
            bitcnt <= '0;
          end else begin
            out_r  <= shreg[0];
            shreg  <= shreg >> 1;
            bitcnt <= bitcnt + 1'b1;
          end
        end
        ST_STOP: begin
          out_r <= LVL_IDLE;
          if (GAP == 0) begin
            state  <= ST_IDLE;
            busy_r <= 1'b0;
          end else begin
            state  <= ST_GAP;
            gapcnt <= GW'(1);
          end
        end
        ST_GAP: begin
          out_r <= LVL_IDLE;
          if (gapcnt == GW'(GAP)) begin
            state  <= ST_IDLE;
            busy_r <= 1'b0;
            gapcnt <= '0;
          end else begin
            gapcnt <= gapcnt + 1'b1;
          end
        end
        default: begin
          state  <= ST_IDLE;
          busy_r <= 1'b0;
          out_r  <= LVL_IDLE;
        end
      endcase
    end
  end

endmodule
